mac_result_drain: RTL and testbench

//  Drain end of the MAC_unit result path: captures each 25-bit signed accumulator result on its output_gogogo pulse.

---
 rtl/conv_pkg.sv | 15 +
 rtl/drain_fifo.sv | 57 +++++
 rtl/mac_result_drain.sv | 129 ++++++++++++
 tb/tb_mac_result_drain.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and the result FIFO entry layout for the MAC result drain path.
package conv_pkg;
    localparam int ACC_W   = 25;
    localparam int OUT_W   = 8;
    localparam int INT_W   = ACC_W + 1;
    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef struct packed {
        logic                    last;
        logic signed [OUT_W-1:0] data;
    } drain_entry_t;

    localparam int ENTRY_W = $bits(drain_entry_t);
endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO with a registered-storage head (no fall-through) and soft clear.
module drain_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [AW:0]                 count;
    logic                        do_pop, do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/mac_result_drain.sv
// MAC result drain: edge capture, round/shift/saturate pipeline, result FIFO, run flags.
// Define MAC_DRAIN_RELU_EN to clamp negative results to zero before saturation.
module mac_result_drain
    import conv_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ACC_W-1:0] mac_out,
    input  logic                    mac_valid,
    input  logic                    start_conv,
    input  logic                    end_conv,
    input  logic [4:0]              cfg_shift,
    input  logic [CNT_W-1:0]        cfg_num_res,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    done,
    output logic                    overflow,
    output logic                    sat_flag
);
    localparam int STAGES = 2;

    logic                    mac_valid_q;
    logic [STAGES:0]         vld_pipe;
    logic signed [ACC_W-1:0] s1_acc;
    logic signed [INT_W-1:0] s2_val;
    logic signed [OUT_W-1:0] s3_data;
    logic [4:0]              shift_q;
    logic [CNT_W-1:0]        num_q, res_cnt;

    logic                    capture, clip, fifo_empty, fifo_full, fifo_drop;
    logic signed [INT_W-1:0] rnd, sum, s2_nxt, clip_in;
    logic signed [OUT_W-1:0] s3_nxt;
    drain_entry_t            push_ent, head_ent;

    assign capture = mac_valid & ~mac_valid_q & start_conv & ~end_conv;

    always_comb begin
        rnd = '0;
        if (shift_q != 5'd0)
            rnd = INT_W'(1) << (shift_q - 5'd1);
        sum    = $signed({s1_acc[ACC_W-1], s1_acc}) + rnd;
        s2_nxt = sum >>> shift_q;
    end

    always_comb begin
        clip_in = s2_val;
`ifdef MAC_DRAIN_RELU_EN
        if (clip_in < 0)
            clip_in = '0;
`endif
        clip   = 1'b0;
        s3_nxt = clip_in[OUT_W-1:0];
        if (clip_in > OUT_MAX) begin
            s3_nxt = OUT_W'(OUT_MAX);
            clip   = 1'b1;
        end else if (clip_in < OUT_MIN) begin
            s3_nxt = OUT_W'(OUT_MIN);
            clip   = 1'b1;
        end
    end

    // last is tagged from the count of results ahead of this one, dropped ones included.
    assign push_ent.data = s3_data;
    assign push_ent.last = (num_q != '0) && (res_cnt == num_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_valid_q <= 1'b0;
            vld_pipe    <= '0;
            s1_acc      <= '0;
            s2_val      <= '0;
            s3_data     <= '0;
            shift_q     <= '0;
            num_q       <= '0;
            res_cnt     <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            sat_flag    <= 1'b0;
        end else if (!start_conv) begin
            mac_valid_q <= 1'b0;
            vld_pipe    <= '0;
            s1_acc      <= '0;
            s2_val      <= '0;
            s3_data     <= '0;
            shift_q     <= cfg_shift;
            num_q       <= cfg_num_res;
            res_cnt     <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            mac_valid_q <= mac_valid;
            vld_pipe    <= {vld_pipe[STAGES-1:0], capture};
            if (capture)     s1_acc  <= mac_out;
            if (vld_pipe[0]) s2_val  <= s2_nxt;
            if (vld_pipe[1]) s3_data <= s3_nxt;
            if (vld_pipe[1] && clip) sat_flag <= 1'b1;
            if (vld_pipe[2]) res_cnt <= res_cnt + 1'b1;
            if (fifo_drop)   overflow <= 1'b1;
            if ((num_q != '0) && (res_cnt == num_q) && fifo_empty)
                done <= 1'b1;
        end
    end

    drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (~start_conv),
        .push      (vld_pipe[2]),
        .push_data (push_ent),
        .pop       (out_ready),
        .head      (head_ent),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = head_ent.data;
    assign out_last  = head_ent.last;
endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: requant vector table plus multi-cycle sequences.
module tb_mac_result_drain;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [24:0]        mac_out = '0;
    logic               mac_valid = 1'b0;
    logic               start_conv = 1'b0;
    logic               end_conv = 1'b0;
    logic [4:0]         cfg_shift = '0;
    logic [15:0]        cfg_num_res = '0;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_last;
    logic               done;
    logic               overflow;
    logic               sat_flag;

    int checks = 0;
    int errors = 0;

    mac_result_drain #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mac_out     (mac_out),
        .mac_valid   (mac_valid),
        .start_conv  (start_conv),
        .end_conv    (end_conv),
        .cfg_shift   (cfg_shift),
        .cfg_num_res (cfg_num_res),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .done        (done),
        .overflow    (overflow),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int acc;
        int shift;
        int exp_data;
        int exp_sat;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_run(input int shift, input int num);
        start_conv  = 1'b0;
        cfg_shift   = 5'(shift);
        cfg_num_res = 16'(num);
        tick();
        start_conv = 1'b1;
        tick();
    endtask

    task automatic pulse(input int acc);
        mac_out   = 25'(acc);
        mac_valid = 1'b1;
        tick();
        mac_valid = 1'b0;
        tick();
    endtask

    function automatic int sd();
        return int'($signed(out_data));
    endfunction

    int neg_relu;
    int xfers, early_done, cnt;
    int got_data[16];
    int got_last[16];

    initial begin
`ifdef MAC_DRAIN_RELU_EN
        neg_relu = 1;
`else
        neg_relu = 0;
`endif
        vecs[0]  = '{1000, 4, 63, 0};
        vecs[1]  = '{-5000, 2, neg_relu ? 0 : -128, neg_relu ? 0 : 1};
        vecs[2]  = '{0, 0, 0, 0};
        vecs[3]  = '{127, 0, 127, 0};
        vecs[4]  = '{128, 0, 127, 1};
        vecs[5]  = '{-128, 0, neg_relu ? 0 : -128, 0};
        vecs[6]  = '{-129, 0, neg_relu ? 0 : -128, neg_relu ? 0 : 1};
        vecs[7]  = '{-3, 1, neg_relu ? 0 : -1, 0};
        vecs[8]  = '{5, 1, 3, 0};
        vecs[9]  = '{16777215, 24, 1, 0};
        vecs[10] = '{-16777216, 24, neg_relu ? 0 : -1, 0};
        vecs[11] = '{2032, 4, 127, 0};
        vecs[12] = '{2040, 4, 127, 1};

        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_flags", int'({out_last, done, overflow, sat_flag}), 0);
        rst = 1'b1;
        tick();

        // Requant table: out_valid must rise exactly 3 clocks after the capturing edge
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            begin_run(vecs[i].shift, 0);
            mac_out   = 25'(vecs[i].acc);
            mac_valid = 1'b1;
            tick();
            mac_valid = 1'b0;
            tick();
            tick();
            chk($sformatf("v%0d_early", i), int'(out_valid), 0);
            tick();
            chk($sformatf("v%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("v%0d_data", i), sd(), vecs[i].exp_data);
            chk($sformatf("v%0d_sat", i), int'(sat_flag), vecs[i].exp_sat);
            chk($sformatf("v%0d_last", i), int'(out_last), 0);
            tick();
            chk($sformatf("v%0d_popped", i), int'(out_valid), 0);
        end

        // Four results with cfg_num_res=4: last only on the 4th, done after drain
        begin_run(4, 4);
        xfers = 0;
        early_done = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid && out_ready && xfers < 16) begin
                got_data[xfers] = sd();
                got_last[xfers] = int'(out_last);
                xfers++;
            end
            if (done && xfers < 4) early_done = 1;
            mac_valid = (c < 8) && (c % 2 == 0);
            mac_out   = 25'(16 * (c / 2 + 1));
            tick();
        end
        chk("seq3_xfers", xfers, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("seq3_data%0d", k), got_data[k], k + 1);
            chk($sformatf("seq3_last%0d", k), got_last[k], (k == 3) ? 1 : 0);
        end
        chk("seq3_early_done", early_done, 0);
        chk("seq3_done", int'(done), 1);
        chk("seq3_overflow", int'(overflow), 0);

        // Ten results into a depth-8 FIFO with the sink stalled
        begin_run(4, 10);
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) pulse(16 * k);
        for (int k = 0; k < 5; k++) tick();
        chk("seq4_overflow", int'(overflow), 1);
        chk("seq4_hold_valid", int'(out_valid), 1);
        chk("seq4_hold_data", sd(), 1);
        chk("seq4_no_done", int'(done), 0);
        out_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && xfers < 16) begin
                got_data[xfers] = sd();
                got_last[xfers] = int'(out_last);
                xfers++;
            end
            tick();
        end
        chk("seq4_xfers", xfers, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("seq4_data%0d", k), got_data[k], k + 1);
            chk($sformatf("seq4_last%0d", k), got_last[k], 0);
        end
        chk("seq4_done", int'(done), 1);

        // Level held high captures once; end_conv blocks new captures
        begin_run(0, 0);
        out_ready = 1'b1;
        mac_out   = 25'(7);
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) cnt++;
            mac_valid = (c < 5);
            tick();
        end
        chk("seq5_level_once", cnt, 1);
        end_conv = 1'b1;
        pulse(9);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("seq5_end_conv", cnt, 0);
        end_conv = 1'b0;

        // start_conv drop discards queued results and clears flags
        begin_run(0, 0);
        out_ready = 1'b0;
        pulse(200);
        pulse(5);
        pulse(6);
        for (int k = 0; k < 4; k++) tick();
        chk("seq6_queued", int'(out_valid), 1);
        chk("seq6_sat", int'(sat_flag), 1);
        chk("seq6_head", sd(), 127);
        start_conv = 1'b0;
        tick();
        chk("seq6_clr_valid", int'(out_valid), 0);
        chk("seq6_clr_flags", int'({out_last, done, overflow, sat_flag}), 0);
        chk("seq6_clr_data", int'(out_data), 0);

        // Asynchronous reset mid-run
        begin_run(0, 0);
        for (int k = 0; k < 10; k++) pulse(300);
        for (int k = 0; k < 4; k++) tick();
        chk("seq6_pre_rst", int'({out_valid, overflow, sat_flag}), 7);
        #2 rst = 1'b0;
        #1;
        chk("seq6_rst_valid", int'(out_valid), 0);
        chk("seq6_rst_data", int'(out_data), 0);
        chk("seq6_rst_flags", int'({out_last, done, overflow, sat_flag}), 0);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
